// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: drives one column per slot, samples the row lines,
// debounces every key and queues press/release events in a small FIFO that
// is read through a valid/ready handshake. Slot/gap timing matches the LED
// matrix driver so both can share the same matrix wiring.
module key_matrix_scanner #(
  parameter int unsigned PERIOD     = 27000,
  parameter int unsigned GAP        = 500,
  parameter int unsigned NCOL       = 4,
  parameter int unsigned NROW       = 4,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  output logic [NCOL-1:0] key_col,
  input  logic [NROW-1:0] key_row,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [3:0]      ev_code,
  output logic            ev_press,
  output logic [15:0]     key_state,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned COL_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int unsigned ROW_W  = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  COL_ON   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0]  COL_OFF  = CNT_W'(PERIOD - GAP);
  localparam logic [CNT_W-1:0]  SNAP_AT  = CNT_W'(PERIOD - GAP - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NCOL - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
  localparam logic [3:0]        DB_LAST  = 4'(DEBOUNCE - 1);

  logic [CNT_W-1:0]  counter;
  logic [COL_W-1:0]  col_index;
  logic [NROW-1:0]   row_meta;
  logic [NROW-1:0]   row_sync;
  logic [NROW-1:0]   row_snap;
  logic [3:0]        db_cnt [16];

  logic [CNT_W-1:0]  eval_off;
  logic              eval_en;
  logic [ROW_W-1:0]  eval_row;
  logic [3:0]        eval_key;
  logic              snap_bit;
  logic              key_flip;

  logic [4:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_full;
  logic              pop;
  logic              do_push;
  logic              drop;

  // Slot counter and column index; column advances on the slot wrap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= '0;
      col_index <= '0;
    end else if (counter == LAST_CNT) begin
      counter   <= '0;
      col_index <= (col_index == LAST_COL) ? '0 : col_index + 1'b1;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // Column drive is active only inside the slot, blanked by GAP at both edges.
  always_comb begin
    key_col = '0;
    if (counter >= COL_ON && counter < COL_OFF)
      key_col[col_index] = 1'b1;
  end

  // Two-flop synchronizer on the rows; snapshot taken on the last driven cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '0;
      row_sync <= '0;
      row_snap <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      if (counter == SNAP_AT)
        row_snap <= row_sync;
    end
  end

  // One row of the current column is evaluated per cycle after the slot ends.
  always_comb begin
    eval_off = counter - COL_OFF;
    eval_en  = (counter >= COL_OFF) && (eval_off < CNT_W'(NROW));
    eval_row = eval_off[ROW_W-1:0];
    eval_key = 4'(col_index * NROW + eval_row);
    snap_bit = row_snap[eval_row];
    key_flip = eval_en && (snap_bit != key_state[eval_key]) &&
               (db_cnt[eval_key] == DB_LAST);
  end

  // Per-key debounce counter and debounced state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state <= '0;
      for (int unsigned k = 0; k < 16; k++)
        db_cnt[k] <= '0;
    end else if (eval_en) begin
      if (snap_bit == key_state[eval_key]) begin
        db_cnt[eval_key] <= '0;
      end else if (key_flip) begin
        key_state[eval_key] <= snap_bit;
        db_cnt[eval_key]    <= '0;
      end else begin
        db_cnt[eval_key] <= db_cnt[eval_key] + 1'b1;
      end
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves this cycle.
  always_comb begin
    fifo_full = (fifo_cnt == FULL_CNT);
    ev_valid  = (fifo_cnt != '0);
    pop       = ev_valid && ev_ready;
    do_push   = key_flip && (!fifo_full || pop);
    drop      = key_flip && fifo_full && !pop;
    ev_code   = fifo_mem[rd_ptr][4:1];
    ev_press  = fifo_mem[rd_ptr][0];
  end

  // Event FIFO storage and pointers; when full, write slot equals the slot being popped.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        fifo_mem[i] <= '0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= {eval_key, snap_bit};
        wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (do_push && !pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !do_push)
        fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle wins over the clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a key-matrix model and an event
// scoreboard. Timing is scaled down (40-cycle slots, 8-cycle gaps).
module tb_key_matrix_scanner;

  localparam int unsigned PERIOD     = 40;
  localparam int unsigned GAP        = 8;
  localparam int unsigned NCOL       = 4;
  localparam int unsigned NROW       = 4;
  localparam int unsigned DEBOUNCE   = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SCAN       = NCOL * PERIOD;

  logic            sys_clk = 1'b0;
  logic            rst_n   = 1'b0;
  logic [NCOL-1:0] key_col;
  logic [NROW-1:0] key_row;
  logic            ev_valid;
  logic            ev_ready;
  logic [3:0]      ev_code;
  logic            ev_press;
  logic [15:0]     key_state;
  logic            overflow;
  logic            ovf_clr;

  logic [15:0]     pressed;
  logic [15:0]     exp_state;
  logic [4:0]      exp_q [$];
  logic [4:0]      mon_e;
  int              n_cmp = 0;
  int              n_mis = 0;
  int unsigned     cyc;

  key_matrix_scanner #(
    .PERIOD(PERIOD), .GAP(GAP), .NCOL(NCOL), .NROW(NROW),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .key_col(key_col), .key_row(key_row),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_press(ev_press), .key_state(key_state), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycles since reset release; equals the DUT's free-running slot position.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Key matrix: a pressed key connects its column line to its row line.
  always_comb begin
    key_row = '0;
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NROW; r++)
        if (key_col[c] && pressed[c*NROW + r]) key_row[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every accepted event must match the oldest expected one.
  always @(negedge sys_clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ev_code", 32'(ev_code), 32'(mon_e[4:1]));
        chk("ev_press", 32'(ev_press), 32'(mon_e[0]));
      end
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_slot_start(input int unsigned col);
    int unsigned guard;
    guard = 0;
    do begin
      @(posedge sys_clk);
      #1;
      guard++;
    end while ((cyc % SCAN) != col * PERIOD && guard < 2 * SCAN);
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Called at a negedge where the DUT slot counter is 0 and column 0 is next.
  task automatic check_col_timeline(input string tag, input int unsigned n);
    logic [3:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      e = '0;
      if ((i % PERIOD) >= GAP && (i % PERIOD) < PERIOD - GAP)
        e = 4'(1 << ((i / PERIOD) % NCOL));
      chk($sformatf("%s_key_col@%0d", tag, i), 32'(key_col), 32'(e));
      @(negedge sys_clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_col"},   32'(key_col),   32'd0);
    chk({tag, "_ev_valid"},  32'(ev_valid),  32'd0);
    chk({tag, "_ev_code"},   32'(ev_code),   32'd0);
    chk({tag, "_ev_press"},  32'(ev_press),  32'd0);
    chk({tag, "_key_state"}, 32'(key_state), 32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    #(2000000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pressed   = '0;
    exp_state = '0;
    ev_ready  = 1'b1;
    ovf_clr   = 1'b0;

    // 1: reset values, column timeline, idle scanning produces nothing
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("t1_rst");
    @(negedge sys_clk);
    rst_n = 1'b1;
    check_col_timeline("t1", PERIOD + GAP + 2);
    wait_cycles(16 * PERIOD - (PERIOD + GAP + 2));
    chk("t1_ev_valid", 32'(ev_valid), 32'd0);
    chk("t1_key_state", 32'(key_state), 32'd0);

    // 3: key 9 seen on only three column-2 scans never registers
    wait_slot_start(2);
    pressed[9] = 1'b1;
    wait_cycles(2 * SCAN + PERIOD);
    pressed[9] = 1'b0;
    wait_cycles(2 * SCAN);
    chk("t3_key_state", 32'(key_state), 32'd0);
    chk("t3_ev_valid", 32'(ev_valid), 32'd0);

    // 2: key 9 held -> press event after the fourth column-2 scan
    wait_slot_start(2);
    pressed[9]    = 1'b1;
    exp_state[9]  = 1'b1;
    exp_q.push_back({4'd9, 1'b1});
    wait_cycles(3 * SCAN);
    chk("t2_not_early", 32'(exp_q.size()), 32'd1);
    wait_drain("t2_drain", 2 * SCAN);
    chk("t2_key_state", 32'(key_state), 32'(exp_state));
    wait_cycles(2 * SCAN);
    chk("t2_key_state_hold", 32'(key_state), 32'h0200);

    // 4: release key 9
    wait_slot_start(2);
    pressed[9]   = 1'b0;
    exp_state[9] = 1'b0;
    exp_q.push_back({4'd9, 1'b0});
    wait_drain("t4_drain", 5 * SCAN);
    chk("t4_key_state", 32'(key_state), 32'(exp_state));

    // 5: four queued events, fifth dropped, ordered drain, overflow clear
    ev_ready = 1'b0;
    wait_slot_start(0);
    pressed = 16'h8421;
    exp_state = 16'h8421;
    exp_q.push_back({4'd0, 1'b1});
    exp_q.push_back({4'd5, 1'b1});
    exp_q.push_back({4'd10, 1'b1});
    exp_q.push_back({4'd15, 1'b1});
    wait_cycles(4 * SCAN);
    chk("t5_ev_valid", 32'(ev_valid), 32'd1);
    chk("t5_head_code", 32'(ev_code), 32'd0);
    chk("t5_head_press", 32'(ev_press), 32'd1);
    chk("t5_ovf_before", 32'(overflow), 32'd0);
    pressed[0]   = 1'b0;
    exp_state[0] = 1'b0;
    wait_cycles(4 * SCAN);
    chk("t5_overflow", 32'(overflow), 32'd1);
    chk("t5_key_state", 32'(key_state), 32'(exp_state));
    chk("t5_head_stable_code", 32'(ev_code), 32'd0);
    chk("t5_head_stable_press", 32'(ev_press), 32'd1);
    ev_ready = 1'b1;
    wait_drain("t5_drain", 20);
    wait_cycles(SCAN);
    chk("t5_empty", 32'(ev_valid), 32'd0);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    wait_cycles(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'd0);

    // 6: reset while two events are queued and a debounce count is running
    ev_ready = 1'b0;
    wait_slot_start(0);
    pressed[5]  = 1'b0;
    pressed[10] = 1'b0;
    wait_cycles(3 * SCAN);
    pressed[3] = 1'b1;
    wait_cycles(SCAN);
    chk("t6_ev_valid", 32'(ev_valid), 32'd1);
    chk("t6_head_code", 32'(ev_code), 32'd5);
    chk("t6_head_press", 32'(ev_press), 32'd0);
    wait_cycles(GAP + 2);
    chk("t6_col_active", 32'(key_col), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    pressed   = '0;
    exp_state = '0;
    ev_ready  = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("t6_hold");
    rst_n = 1'b1;
    check_col_timeline("t6", PERIOD + GAP + 2);
    wait_cycles(2 * SCAN);
    chk("t6_key_state", 32'(key_state), 32'(exp_state));
    chk("t6_ev_valid_after", 32'(ev_valid), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
